// File: rtl/rf_pkg.sv
// Shared register-file constants and types for the writeback arbiter slice.
package rf_pkg;
    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, register-file write port and hazard-check signals.
interface regfile_wb_arbiter_if #(
    parameter int NUM_SRC = 2,
    parameter int XLEN    = rf_pkg::XLEN
);
    import rf_pkg::*;

    logic [NUM_SRC-1:0]            i_src_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] i_src_sel;
    logic [NUM_SRC*XLEN-1:0]       i_src_dat;
    logic [NUM_SRC-1:0]            o_src_ready;
    logic                          o_rf_we;
    reg_addr_t                     o_rf_sel_w;
    logic [XLEN-1:0]               o_rf_dat_w;
    logic                          i_issue_valid;
    reg_addr_t                     i_issue_rd;
    reg_addr_t                     i_chk_a;
    reg_addr_t                     i_chk_b;
    logic                          o_busy_a;
    logic                          o_busy_b;

    modport master (
        output i_src_valid, i_src_sel, i_src_dat, i_issue_valid, i_issue_rd, i_chk_a, i_chk_b,
        input  o_src_ready, o_rf_we, o_rf_sel_w, o_rf_dat_w, o_busy_a, o_busy_b
    );

    modport slave (
        input  i_src_valid, i_src_sel, i_src_dat, i_issue_valid, i_issue_rd, i_chk_a, i_chk_b,
        output o_src_ready, o_rf_we, o_rf_sel_w, o_rf_dat_w, o_busy_a, o_busy_b
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);
    always_comb begin
        int   k;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port with a registered write
// stage and a pending-write scoreboard for RAW hazard stalls.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int XLEN    = rf_pkg::XLEN
) (
    input logic           i_clk,
    input logic           i_reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PTR_W-1:0]    rr_ptr;
    logic [NUM_SRC-1:0]  grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                grant_any;
    reg_addr_t           sel_g;
    logic [XLEN-1:0]     dat_g;
    logic [NUM_REGS-1:0] sb;
    logic [NUM_REGS-1:0] sb_nxt;

    rr_arbiter #(.N(NUM_SRC), .IDX_W(PTR_W)) u_arb (
        .req       (bus.i_src_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign grant_any       = |grant;
    assign bus.o_src_ready = i_reset ? '0 : grant;
    assign sel_g           = bus.i_src_sel[int'(grant_idx)*REG_ADDR_W +: REG_ADDR_W];
    assign dat_g           = bus.i_src_dat[int'(grant_idx)*XLEN +: XLEN];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            if (grant_idx == PTR_W'(NUM_SRC - 1)) rr_ptr <= '0;
            else                                  rr_ptr <= grant_idx + 1'b1;
        end
    end

    // x0 requests are consumed but never reach the register file.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bus.o_rf_we    <= 1'b0;
            bus.o_rf_sel_w <= '0;
            bus.o_rf_dat_w <= '0;
        end else begin
            bus.o_rf_we <= grant_any && (sel_g != '0);
            if (grant_any) begin
                bus.o_rf_sel_w <= sel_g;
                bus.o_rf_dat_w <= dat_g;
            end
        end
    end

    // A new producer issuing in the same cycle as the old write retires keeps the bit set.
    always_comb begin
        sb_nxt = sb;
        if (bus.o_rf_we) sb_nxt[bus.o_rf_sel_w] = 1'b0;
        if (bus.i_issue_valid && (bus.i_issue_rd != '0)) sb_nxt[bus.i_issue_rd] = 1'b1;
        sb_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) sb <= '0;
        else         sb <= sb_nxt;
    end

    assign bus.o_busy_a = (bus.i_chk_a != '0) && sb[bus.i_chk_a] &&
                          !(bus.o_rf_we && (bus.o_rf_sel_w == bus.i_chk_a));
    assign bus.o_busy_b = (bus.i_chk_b != '0) && sb[bus.i_chk_b] &&
                          !(bus.o_rf_we && (bus.o_rf_sel_w == bus.i_chk_b));
endmodule
